// File: rtl/e203_csr_access_arb.sv
// e203_csr_access_arb: shares the single CSR file port between EXU and DBG and buffers one response.
// Define E203_CSR_ARB_RR_EN for round-robin arbitration; the default build gives DBG fixed priority.
module e203_csr_access_arb #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             exu_req_valid,
  output logic             exu_req_ready,
  input  logic [IDX_W-1:0] exu_req_idx,
  input  logic [1:0]       exu_req_op,
  input  logic             exu_req_rs1is0,
  input  logic             exu_req_rdwen,
  input  logic [XLEN-1:0]  exu_req_wdat,
  output logic             exu_rsp_valid,
  input  logic             exu_rsp_ready,
  output logic [XLEN-1:0]  exu_rsp_rdat,
  output logic             exu_rsp_err,

  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic [IDX_W-1:0] dbg_req_idx,
  input  logic [1:0]       dbg_req_op,
  input  logic             dbg_req_rs1is0,
  input  logic             dbg_req_rdwen,
  input  logic [XLEN-1:0]  dbg_req_wdat,
  output logic             dbg_rsp_valid,
  input  logic             dbg_rsp_ready,
  output logic [XLEN-1:0]  dbg_rsp_rdat,
  output logic             dbg_rsp_err,

  output logic             csr_ena,
  output logic             csr_rd_en,
  output logic             csr_wr_en,
  output logic [IDX_W-1:0] csr_idx,
  output logic [XLEN-1:0]  wbck_csr_dat,
  input  logic [XLEN-1:0]  read_csr_dat,
  input  logic             csr_access_ilgl
);

  logic            rspVld_q, rspVld_d;
  logic            rspOwn_q, rspOwn_d;
  logic [XLEN-1:0] rspRdat_q, rspRdat_d;
  logic            rspErr_q, rspErr_d;

  logic             ownerHsk, free, gnt, pickDbg;
  logic [IDX_W-1:0] selIdx;
  logic [1:0]       selOp;
  logic             selRs1is0, selRdwen;
  logic [XLEN-1:0]  selWdat;
  logic             isRw, isRs, isRc, noWrite;
  logic             exuShow, dbgShow;

  // The buffer may be drained and refilled in the same cycle.
  assign ownerHsk = rspVld_q & (rspOwn_q ? dbg_rsp_ready : exu_rsp_ready);
  assign free     = ~rspVld_q | ownerHsk;
  assign gnt      = ~rst & free & (exu_req_valid | dbg_req_valid);

`ifdef E203_CSR_ARB_RR_EN
  logic lastGnt_q;

  // On a conflict the requester that did not win last time goes first.
  assign pickDbg = dbg_req_valid & (~exu_req_valid | ~lastGnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt_q <= 1'b0;
    end else if (gnt) begin
      lastGnt_q <= pickDbg;
    end
  end
`else
  assign pickDbg = dbg_req_valid;
`endif

  assign selIdx    = pickDbg ? dbg_req_idx    : exu_req_idx;
  assign selOp     = pickDbg ? dbg_req_op     : exu_req_op;
  assign selRs1is0 = pickDbg ? dbg_req_rs1is0 : exu_req_rs1is0;
  assign selRdwen  = pickDbg ? dbg_req_rdwen  : exu_req_rdwen;
  assign selWdat   = pickDbg ? dbg_req_wdat   : exu_req_wdat;

  // Reserved op 00 behaves as a set with a zero source, i.e. a pure read.
  assign isRw    = (selOp == 2'b01);
  assign isRc    = (selOp == 2'b11);
  assign isRs    = (selOp == 2'b10) | (selOp == 2'b00);
  assign noWrite = selRs1is0 | (selOp == 2'b00);

  assign exu_req_ready = gnt & ~pickDbg;
  assign dbg_req_ready = gnt & pickDbg;

  always_comb begin
    csr_ena      = 1'b0;
    csr_rd_en    = 1'b0;
    csr_wr_en    = 1'b0;
    csr_idx      = '0;
    wbck_csr_dat = '0;
    if (gnt) begin
      csr_ena   = 1'b1;
      csr_idx   = selIdx;
      csr_rd_en = isRs | isRc | (isRw & selRdwen);
      csr_wr_en = isRw | ((isRs | isRc) & ~noWrite);
      if (isRw) begin
        wbck_csr_dat = selWdat;
      end else if (isRc) begin
        wbck_csr_dat = ~selWdat & read_csr_dat;
      end else begin
        wbck_csr_dat = selWdat | read_csr_dat;
      end
    end
  end

  always_comb begin
    rspVld_d  = rspVld_q;
    rspOwn_d  = rspOwn_q;
    rspRdat_d = rspRdat_q;
    rspErr_d  = rspErr_q;
    if (gnt) begin
      rspVld_d  = 1'b1;
      rspOwn_d  = pickDbg;
      rspRdat_d = read_csr_dat;
      rspErr_d  = csr_access_ilgl;
    end else if (ownerHsk) begin
      rspVld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rspVld_q  <= 1'b0;
      rspOwn_q  <= 1'b0;
      rspRdat_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      rspVld_q  <= rspVld_d;
      rspOwn_q  <= rspOwn_d;
      rspRdat_q <= rspRdat_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // Only the owning port sees the buffered response; the other reads as zero.
  assign exuShow       = ~rst & rspVld_q & ~rspOwn_q;
  assign dbgShow       = ~rst & rspVld_q & rspOwn_q;
  assign exu_rsp_valid = exuShow;
  assign exu_rsp_rdat  = exuShow ? rspRdat_q : '0;
  assign exu_rsp_err   = exuShow & rspErr_q;
  assign dbg_rsp_valid = dbgShow;
  assign dbg_rsp_rdat  = dbgShow ? rspRdat_q : '0;
  assign dbg_rsp_err   = dbgShow & rspErr_q;

endmodule

// File: tb/tb_e203_csr_access_arb.sv
// Scoreboard bench for e203_csr_access_arb: directed scenarios then random traffic against a reference model.
// Follows E203_CSR_ARB_RR_EN to choose the expected arbitration policy.
module tb_e203_csr_access_arb;
  localparam int XLEN  = 32;
  localparam int IDX_W = 12;

  typedef struct packed {
    logic             rst;
    logic [1:0]       v;
    logic [1:0][1:0]  op;
    logic [1:0][11:0] idx;
    logic [1:0]       rs0;
    logic [1:0]       rdwen;
    logic [1:0][31:0] wdat;
    logic [1:0]       rdy;
  } stim_t;

  typedef struct packed {
    logic        own;
    logic [31:0] rdat;
    logic        err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             exu_req_valid = 1'b0, exu_req_ready;
  logic [IDX_W-1:0] exu_req_idx = '0;
  logic [1:0]       exu_req_op = '0;
  logic             exu_req_rs1is0 = 1'b0, exu_req_rdwen = 1'b0;
  logic [XLEN-1:0]  exu_req_wdat = '0;
  logic             exu_rsp_valid, exu_rsp_ready = 1'b0;
  logic [XLEN-1:0]  exu_rsp_rdat;
  logic             exu_rsp_err;
  logic             dbg_req_valid = 1'b0, dbg_req_ready;
  logic [IDX_W-1:0] dbg_req_idx = '0;
  logic [1:0]       dbg_req_op = '0;
  logic             dbg_req_rs1is0 = 1'b0, dbg_req_rdwen = 1'b0;
  logic [XLEN-1:0]  dbg_req_wdat = '0;
  logic             dbg_rsp_valid, dbg_rsp_ready = 1'b0;
  logic [XLEN-1:0]  dbg_rsp_rdat;
  logic             dbg_rsp_err;
  logic             csr_ena, csr_rd_en, csr_wr_en;
  logic [IDX_W-1:0] csr_idx;
  logic [XLEN-1:0]  wbck_csr_dat, read_csr_dat;
  logic             csr_access_ilgl;

  logic [31:0] csrMem [16];
  int          compared = 0;
  int          mismatched = 0;
  rsp_t        expQ[$];
  bit          bufVld = 0;
  bit          bufOwn = 0;
`ifdef E203_CSR_ARB_RR_EN
  bit          lastGnt = 0;
`endif
  bit          pendWr = 0;
  logic [3:0]  pendIdx = '0;
  logic [31:0] pendDat = '0;

  // Small CSR file stand-in: 16 entries, indices ending in E/F are illegal.
  assign read_csr_dat    = csrMem[csr_idx[3:0]];
  assign csr_access_ilgl = (csr_idx[3:0] >= 4'hE);

  always #5 clk = ~clk;

  e203_csr_access_arb #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .exu_req_valid(exu_req_valid), .exu_req_ready(exu_req_ready), .exu_req_idx(exu_req_idx),
    .exu_req_op(exu_req_op), .exu_req_rs1is0(exu_req_rs1is0), .exu_req_rdwen(exu_req_rdwen),
    .exu_req_wdat(exu_req_wdat), .exu_rsp_valid(exu_rsp_valid), .exu_rsp_ready(exu_rsp_ready),
    .exu_rsp_rdat(exu_rsp_rdat), .exu_rsp_err(exu_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_idx(dbg_req_idx),
    .dbg_req_op(dbg_req_op), .dbg_req_rs1is0(dbg_req_rs1is0), .dbg_req_rdwen(dbg_req_rdwen),
    .dbg_req_wdat(dbg_req_wdat), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdat(dbg_rsp_rdat), .dbg_rsp_err(dbg_rsp_err),
    .csr_ena(csr_ena), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .wbck_csr_dat(wbck_csr_dat), .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rdy = 2'b11;
    return s;
  endfunction

  function automatic stim_t withReq(input stim_t si, input int p, input logic [1:0] op,
                                    input logic [11:0] idx, input logic rs0, input logic rdwen,
                                    input logic [31:0] wdat);
    stim_t s;
    s = si;
    s.v[p] = 1'b1;
    s.op[p] = op;
    s.idx[p] = idx;
    s.rs0[p] = rs0;
    s.rdwen[p] = rdwen;
    s.wdat[p] = wdat;
    return s;
  endfunction

  // Who the arbiter should grant this cycle: -1 none, 0 EXU, 1 DBG.
  function automatic int pickWinner(input stim_t s);
    bit isFree;
    if (s.rst) return -1;
    isFree = !bufVld || s.rdy[bufOwn];
    if (!isFree) return -1;
    if (s.v[0] && s.v[1]) begin
`ifdef E203_CSR_ARB_RR_EN
      return (lastGnt == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (s.v[1]) return 1;
    if (s.v[0]) return 0;
    return -1;
  endfunction

  task automatic checkOutput(input stim_t s, input int w, output logic expWr, output logic [31:0] expWb);
    logic [1:0]  op;
    logic [31:0] old, wd;
    logic        expRd, zeroSrc;
    expWr = 1'b0;
    expWb = '0;
    expRd = 1'b0;
    if (w >= 0) begin
      op      = s.op[w];
      wd      = s.wdat[w];
      old     = csrMem[s.idx[w][3:0]];
      zeroSrc = s.rs0[w] || (op == 2'b00);
      case (op)
        2'b01:   begin expRd = s.rdwen[w]; expWr = 1'b1;     expWb = wd;        end
        2'b11:   begin expRd = 1'b1;       expWr = !zeroSrc; expWb = ~wd & old; end
        default: begin expRd = 1'b1;       expWr = !zeroSrc; expWb = wd | old;  end
      endcase
    end
    check("exuReqReady", 64'(exu_req_ready), 64'(w == 0));
    check("dbgReqReady", 64'(dbg_req_ready), 64'(w == 1));
    check("csrEna", 64'(csr_ena), 64'(w >= 0));
    check("csrIdx", 64'(csr_idx), (w >= 0) ? 64'(s.idx[w]) : 64'd0);
    check("csrRdEn", 64'(csr_rd_en), 64'(expRd));
    check("csrWrEn", 64'(csr_wr_en), 64'(expWr));
    check("wbckDat", 64'(wbck_csr_dat), 64'(expWb));
    check("exuRspValid", 64'(exu_rsp_valid), 64'(!s.rst && bufVld && bufOwn == 0));
    check("dbgRspValid", 64'(dbg_rsp_valid), 64'(!s.rst && bufVld && bufOwn == 1));
  endtask

  task automatic modelStep(input stim_t s, input int w, input logic expWr, input logic [31:0] expWb);
    rsp_t r;
    if (s.rst) begin
      bufVld = 0;
      bufOwn = 0;
`ifdef E203_CSR_ARB_RR_EN
      lastGnt = 0;
`endif
      expQ.delete();
      pendWr = 0;
      return;
    end
    if (w >= 0) begin
      r.own  = w[0];
      r.rdat = csrMem[s.idx[w][3:0]];
      r.err  = (s.idx[w][3:0] >= 4'hE);
      expQ.push_back(r);
      if (expWr && !r.err) begin
        pendWr  = 1;
        pendIdx = s.idx[w][3:0];
        pendDat = expWb;
      end
      bufVld = 1;
      bufOwn = w[0];
`ifdef E203_CSR_ARB_RR_EN
      lastGnt = w[0];
`endif
    end else if (bufVld && s.rdy[bufOwn]) begin
      bufVld = 0;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    int          w;
    logic        expWr;
    logic [31:0] expWb;
    @(posedge clk);
    #1;
    if (pendWr) begin
      csrMem[pendIdx] = pendDat;
      pendWr = 0;
    end
    rst            = s.rst;
    exu_req_valid  = s.v[0];     dbg_req_valid  = s.v[1];
    exu_req_op     = s.op[0];    dbg_req_op     = s.op[1];
    exu_req_idx    = s.idx[0];   dbg_req_idx    = s.idx[1];
    exu_req_rs1is0 = s.rs0[0];   dbg_req_rs1is0 = s.rs0[1];
    exu_req_rdwen  = s.rdwen[0]; dbg_req_rdwen  = s.rdwen[1];
    exu_req_wdat   = s.wdat[0];  dbg_req_wdat   = s.wdat[1];
    exu_rsp_ready  = s.rdy[0];   dbg_rsp_ready  = s.rdy[1];
    @(negedge clk);
    w = pickWinner(s);
    checkOutput(s, w, expWr, expWb);
    modelStep(s, w, expWr, expWb);
  endtask

  task automatic checkResponse(input int port, input logic [31:0] rdat, input logic err, input logic rdy);
    rsp_t r;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL rspUnexpected: port %0d shows a response, none expected", port);
      return;
    end
    r = expQ[0];
    check("rspOwner", 64'(port), 64'(r.own));
    check("rspRdat", 64'(rdat), 64'(r.rdat));
    check("rspErr", 64'(err), 64'(r.err));
    if (rdy) void'(expQ.pop_front());
  endtask

  // Response monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (exu_rsp_valid) checkResponse(0, exu_rsp_rdat, exu_rsp_err, exu_rsp_ready);
      else check("exuIdleRsp", {31'd0, exu_rsp_rdat, exu_rsp_err}, 64'd0);
      if (dbg_rsp_valid) checkResponse(1, dbg_rsp_rdat, dbg_rsp_err, dbg_rsp_ready);
      else check("dbgIdleRsp", {31'd0, dbg_rsp_rdat, dbg_rsp_err}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) csrMem[i] = $urandom;
    csrMem[0] = 32'h0000_1234;
    csrMem[2] = 32'h0000_00FF;

    // Reset with requests pending, then one quiet cycle.
    s = withReq(withReq(idleStim(), 0, 2'b01, 12'h340, 1'b0, 1'b1, 32'h1), 1, 2'b10, 12'h341, 1'b0, 1'b1, 32'h2);
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());

    // RW write with read.
    applyStimulus(withReq(idleStim(), 0, 2'b01, 12'h340, 1'b0, 1'b1, 32'hA5A5_0000));
    applyStimulus(idleStim());

    // RS with x0 source, then RC clearing low nibble.
    applyStimulus(withReq(idleStim(), 0, 2'b10, 12'h341, 1'b1, 1'b0, 32'hFFFF_FFFF));
    applyStimulus(withReq(idleStim(), 0, 2'b11, 12'h342, 1'b0, 1'b0, 32'h0000_000F));
    applyStimulus(idleStim());

    // Four-cycle conflict.
    s = withReq(withReq(idleStim(), 0, 2'b10, 12'h343, 1'b1, 1'b0, 32'h0), 1, 2'b10, 12'h344, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(s);
    applyStimulus(idleStim());

    // Backpressure for three cycles, then drain and refill together.
    s = withReq(idleStim(), 0, 2'b01, 12'h345, 1'b0, 1'b1, 32'hDEAD_BEEF);
    s.rdy = 2'b00;
    applyStimulus(s);
    s.wdat[0] = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.rdy = 2'b11;
    applyStimulus(s);
    applyStimulus(idleStim());

    // Illegal index.
    applyStimulus(withReq(idleStim(), 1, 2'b01, 12'h34F, 1'b0, 1'b1, 32'h5555_5555));
    applyStimulus(idleStim());

    // Reset while a response is waiting, then a conflict right after.
    s = withReq(idleStim(), 0, 2'b10, 12'h346, 1'b1, 1'b0, 32'h0);
    s.rdy = 2'b00;
    applyStimulus(s);
    s = withReq(s, 1, 2'b10, 12'h347, 1'b1, 1'b0, 32'h0);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    s.rdy = 2'b11;
    applyStimulus(s);
    applyStimulus(idleStim());

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      s = idleStim();
      for (int p = 0; p < 2; p++) begin
        s.v[p]     = ($urandom_range(0, 9) < 6);
        s.op[p]    = 2'($urandom_range(0, 3));
        s.idx[p]   = {8'h34, 4'($urandom_range(0, 15))};
        s.rs0[p]   = ($urandom_range(0, 3) == 0);
        s.rdwen[p] = 1'($urandom_range(0, 1));
        s.wdat[p]  = $urandom;
        s.rdy[p]   = ($urandom_range(0, 9) < 7);
      end
      s.rst = ($urandom_range(0, 99) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 3; i++) applyStimulus(idleStim());
    check("queueDrained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
